// File: rtl/butterfly_read_sequencer.sv
// Stage-by-stage row-pair read sequencer for the radix-2 FFT datapath.
// Issues paired SRAM row reads and delivers the matching crossbar stride one cycle later.
module butterfly_read_sequencer #(
    parameter int N_LOG2    = 10,
    parameter int STAGE_GAP = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_START,
    input  logic              i_STALL,
    output logic              o_BUSY,
    output logic              o_RD_EN,
    output logic [N_LOG2-3:0] o_RD_ADDR1,
    output logic [N_LOG2-3:0] o_RD_ADDR2,
    output logic [3:0]        o_STAGE,
    output logic              o_DATA_VALID,
    output logic [9:0]        o_DATA_STRIDE,
    output logic              o_DONE
);
    localparam int ROW_W = N_LOG2 - 2;
    localparam int PW    = N_LOG2 - 3;
    localparam logic [3:0] LAST_STAGE = 4'(N_LOG2 - 1);
    localparam logic [3:0] GAP_LAST   = 4'(STAGE_GAP - 1);
    localparam logic [9:0] MAX_STRIDE = 10'(1 << (N_LOG2 - 1));

    typedef enum logic [1:0] {IDLE, READ, GAP, FIN} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       s_reg, s_next;
    logic [PW-1:0]    p_reg, p_next;
    logic [9:0]       stride_reg, stride_next;
    logic [3:0]       gap_cnt_reg, gap_cnt_next;
    logic             busy_reg, busy_next;
    logic             rd_en_reg, rd_en_next;
    logic [ROW_W-1:0] addr1_reg, addr1_next;
    logic [ROW_W-1:0] addr2_reg, addr2_next;
    logic [3:0]       stage_reg, stage_next;
    logic [9:0]       rd_stride_reg, rd_stride_next;
    logic             data_valid_reg, data_valid_next;
    logic [9:0]       data_stride_reg, data_stride_next;
    logic             done_reg, done_next;

    // Row distance k is S/4 for wide strides and 1 once the pair shares a row group.
    logic [ROW_W-1:0] k_dist, low_mask, p_ext, row_a;
    assign k_dist   = (stride_reg >= 10'd4) ? ROW_W'(stride_reg >> 2) : ROW_W'(1);
    assign low_mask = k_dist - ROW_W'(1);
    assign p_ext    = ROW_W'(p_reg);
    // Insert a zero at bit log2(k): high bits of p move up one place.
    assign row_a    = ((p_ext & ~low_mask) << 1) | (p_ext & low_mask);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_reg       <= IDLE;
            s_reg           <= '0;
            p_reg           <= '0;
            stride_reg      <= '0;
            gap_cnt_reg     <= '0;
            busy_reg        <= 1'b0;
            rd_en_reg       <= 1'b0;
            addr1_reg       <= '0;
            addr2_reg       <= '0;
            stage_reg       <= '0;
            rd_stride_reg   <= '0;
            data_valid_reg  <= 1'b0;
            data_stride_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            s_reg           <= s_next;
            p_reg           <= p_next;
            stride_reg      <= stride_next;
            gap_cnt_reg     <= gap_cnt_next;
            busy_reg        <= busy_next;
            rd_en_reg       <= rd_en_next;
            addr1_reg       <= addr1_next;
            addr2_reg       <= addr2_next;
            stage_reg       <= stage_next;
            rd_stride_reg   <= rd_stride_next;
            data_valid_reg  <= data_valid_next;
            data_stride_reg <= data_stride_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        s_next           = s_reg;
        p_next           = p_reg;
        stride_next      = stride_reg;
        gap_cnt_next     = gap_cnt_reg;
        busy_next        = busy_reg;
        rd_en_next       = 1'b0;
        addr1_next       = addr1_reg;
        addr2_next       = addr2_reg;
        stage_next       = stage_reg;
        rd_stride_next   = rd_stride_reg;
        data_valid_next  = rd_en_reg;
        data_stride_next = rd_en_reg ? rd_stride_reg : data_stride_reg;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_START) begin
                    state_next   = READ;
                    busy_next    = 1'b1;
                    s_next       = '0;
                    p_next       = '0;
                    stride_next  = MAX_STRIDE;
                    gap_cnt_next = '0;
                end
            end
            READ: begin
                if (!i_STALL) begin
                    rd_en_next     = 1'b1;
                    addr1_next     = row_a;
                    addr2_next     = row_a + k_dist;
                    stage_next     = s_reg;
                    rd_stride_next = stride_reg;
                    p_next         = p_reg + PW'(1);
                    if (&p_reg) begin
                        gap_cnt_next = '0;
                        if (s_reg == LAST_STAGE) begin
                            state_next = FIN;
                        end else if (STAGE_GAP == 0) begin
                            s_next      = s_reg + 4'd1;
                            stride_next = stride_reg >> 1;
                        end else begin
                            state_next = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    s_next       = s_reg + 4'd1;
                    stride_next  = stride_reg >> 1;
                    state_next   = READ;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            FIN: begin
                // First FIN cycle lets the last read data arrive; the second one signals completion.
                if (gap_cnt_reg == 4'd0) begin
                    gap_cnt_next = 4'd1;
                end else begin
                    gap_cnt_next = '0;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_BUSY        = busy_reg;
    assign o_RD_EN       = rd_en_reg;
    assign o_RD_ADDR1    = addr1_reg;
    assign o_RD_ADDR2    = addr2_reg;
    assign o_STAGE       = stage_reg;
    assign o_DATA_VALID  = data_valid_reg;
    assign o_DATA_STRIDE = data_stride_reg;
    assign o_DONE        = done_reg;
endmodule

// File: tb/tb_butterfly_read_sequencer.sv
// Bench for butterfly_read_sequencer: two configurations (N_LOG2=4/GAP=2 and N_LOG2=10/GAP=0)
// driven by shared stimulus and compared every cycle against a slot-schedule model.
module tb_butterfly_read_sequencer;
    logic clk;
    logic rst_n;
    logic start;
    logic stall;

    logic [1:0] busy_w, rd_en_w, dv_w, done_w;
    logic [9:0] a1_w [2];
    logic [9:0] a2_w [2];
    logic [3:0] stage_w [2];
    logic [9:0] dstride_w [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit rd;
        int s;
        int a;
        int b;
        int stride;
    } slot_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int row_k(input int nlog, input int s);
        int st;
        st = (1 << nlog) >> (s + 1);
        return (st / 4 > 1) ? st / 4 : 1;
    endfunction

    function automatic int row_a(input int nlog, input int s, input int p);
        int k;
        k = row_k(nlog, s);
        return (p / k) * 2 * k + (p % k);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cfg
            localparam int NLOG = (gi == 0) ? 4 : 10;
            localparam int GAPC = (gi == 0) ? 2 : 0;

            logic busy, rd_en, dv, done;
            logic [NLOG-3:0] a1, a2;
            logic [3:0] stage;
            logic [9:0] dstride;

            butterfly_read_sequencer #(.N_LOG2(NLOG), .STAGE_GAP(GAPC)) dut (
                .i_CLK(clk),
                .i_RST_N(rst_n),
                .i_START(start),
                .i_STALL(stall),
                .o_BUSY(busy),
                .o_RD_EN(rd_en),
                .o_RD_ADDR1(a1),
                .o_RD_ADDR2(a2),
                .o_STAGE(stage),
                .o_DATA_VALID(dv),
                .o_DATA_STRIDE(dstride),
                .o_DONE(done)
            );

            assign busy_w[gi]    = busy;
            assign rd_en_w[gi]   = rd_en;
            assign dv_w[gi]      = dv;
            assign done_w[gi]    = done;
            assign a1_w[gi]      = 10'(a1);
            assign a2_w[gi]      = 10'(a2);
            assign stage_w[gi]   = stage;
            assign dstride_w[gi] = dstride;

            // Whole transform as a list of issue slots: one per read, one per gap cycle.
            slot_t slots[$];
            bit running = 0;
            int ptr = 0;
            int tail = 0;
            bit e_busy = 0, e_rd = 0, e_dv = 0, e_done = 0;
            int e_a = 0, e_b = 0, e_s = 0, e_rstride = 0, e_dstride = 0;

            initial begin
                for (int s = 0; s < NLOG; s++) begin
                    for (int p = 0; p < (1 << NLOG) / 8; p++)
                        slots.push_back('{1'b1, s, row_a(NLOG, s, p),
                                         row_a(NLOG, s, p) + row_k(NLOG, s), (1 << NLOG) >> (s + 1)});
                    if (s < NLOG - 1)
                        for (int g = 0; g < GAPC; g++) slots.push_back('{1'b0, s, 0, 0, 0});
                end
            end

            always @(posedge clk) begin
                if (!rst_n) begin
                    running = 0; ptr = 0; tail = 0;
                    e_busy = 0; e_rd = 0; e_dv = 0; e_done = 0;
                    e_a = 0; e_b = 0; e_s = 0; e_rstride = 0; e_dstride = 0;
                end else begin
                    e_dv = e_rd;
                    if (e_rd) e_dstride = e_rstride;
                    e_rd = 0;
                    e_done = 0;
                    if (!running) begin
                        if (start) begin
                            running = 1; ptr = 0; tail = 0; e_busy = 1;
                        end
                    end else if (ptr < int'(slots.size())) begin
                        if (!(slots[ptr].rd && stall)) begin
                            if (slots[ptr].rd) begin
                                e_rd = 1;
                                e_a = slots[ptr].a;
                                e_b = slots[ptr].b;
                                e_s = slots[ptr].s;
                                e_rstride = slots[ptr].stride;
                            end
                            ptr++;
                        end
                    end else if (tail == 0) begin
                        tail = 1;
                    end else begin
                        e_done = 1; e_busy = 0; running = 0;
                    end
                end
                #1;
                check($sformatf("c%0d_busy", gi), 32'(busy), 32'(e_busy));
                check($sformatf("c%0d_rd_en", gi), 32'(rd_en), 32'(e_rd));
                check($sformatf("c%0d_data_valid", gi), 32'(dv), 32'(e_dv));
                check($sformatf("c%0d_done", gi), 32'(done), 32'(e_done));
                check($sformatf("c%0d_addr1", gi), 32'(a1), e_a);
                check($sformatf("c%0d_addr2", gi), 32'(a2), e_b);
                check($sformatf("c%0d_stage", gi), 32'(stage), e_s);
                check($sformatf("c%0d_data_stride", gi), 32'(dstride), e_dstride);
            end
        end
    endgenerate

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_c%0d_busy", tag, i), 32'(busy_w[i]), 0);
            check($sformatf("%s_c%0d_rd_en", tag, i), 32'(rd_en_w[i]), 0);
            check($sformatf("%s_c%0d_dv", tag, i), 32'(dv_w[i]), 0);
            check($sformatf("%s_c%0d_done", tag, i), 32'(done_w[i]), 0);
            check($sformatf("%s_c%0d_addr1", tag, i), 32'(a1_w[i]), 0);
            check($sformatf("%s_c%0d_addr2", tag, i), 32'(a2_w[i]), 0);
            check($sformatf("%s_c%0d_stage", tag, i), 32'(stage_w[i]), 0);
            check($sformatf("%s_c%0d_dstride", tag, i), 32'(dstride_w[i]), 0);
        end
    endtask

    // One START, then watch both DUTs until each pulses DONE; stall pattern is edge-relative.
    task automatic run_txn(input string tag, input int stall_from, input int stall_len, input bit rnd,
                           input int busy_pulse, output int lat0, output int lat1,
                           output int rd0, output int rd1);
        int n;
        lat0 = -1; lat1 = -1; rd0 = 0; rd1 = 0; n = 0;
        @(negedge clk);
        start = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        while ((lat0 < 0 || lat1 < 0) && n < 4000) begin
            @(negedge clk);
            start = (n + 1 == busy_pulse);
            if (rnd) stall = ($urandom_range(0, 3) == 0);
            else     stall = (n + 1 >= stall_from) && (n + 1 < stall_from + stall_len);
            @(posedge clk);
            n++;
            #1;
            if (rd_en_w[0]) rd0++;
            if (rd_en_w[1]) rd1++;
            if (done_w[0] && lat0 < 0) lat0 = n;
            if (done_w[1] && lat1 < 0) lat1 = n;
        end
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        check({tag, "_timeout"}, 32'(lat0 < 0 || lat1 < 0), 0);
        $display("txn %s lat0=%0d lat1=%0d reads0=%0d reads1=%0d", tag, lat0, lat1, rd0, rd1);
    endtask

    initial begin
        int l0, l1, r0, r1, n, first, second;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        check("pin_a_n4_s0_p1", row_a(4, 0, 1), 1);
        check("pin_b_n4_s0_p1", row_a(4, 0, 1) + row_k(4, 0), 3);
        check("pin_a_n4_s1_p1", row_a(4, 1, 1), 2);
        check("pin_b_n10_s0_p127", row_a(10, 0, 127) + row_k(10, 0), 255);
        check("pin_a_n10_s7_p1", row_a(10, 7, 1), 2);

        run_txn("plain", 0, 0, 1'b0, 3, l0, l1, r0, r1);
        check("plain_lat0", l0, 16);
        check("plain_lat1", l1, 1282);
        check("plain_reads0", r0, 8);
        check("plain_reads1", r1, 1280);

        run_txn("stall3", 6, 3, 1'b0, 0, l0, l1, r0, r1);
        check("stall3_lat0", l0, 19);
        check("stall3_lat1", l1, 1285);
        check("stall3_reads0", r0, 8);
        check("stall3_reads1", r1, 1280);

        for (int i = 0; i < 2; i++) begin
            run_txn($sformatf("rand%0d", i), 0, 0, 1'b1, 5, l0, l1, r0, r1);
            check($sformatf("rand%0d_reads0", i), r0, 8);
            check($sformatf("rand%0d_reads1", i), r1, 1280);
        end

        // START held high: the small configuration restarts right after each DONE.
        @(negedge clk);
        start = 1'b1;
        n = 0; first = -1; second = -1;
        while (second < 0 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done_w[0]) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_first_done", first, 17);
        check("b2b_spacing", second - first, 17);
        $display("txn b2b first=%0d second=%0d", first, second);
        n = 0;
        while (busy_w != 2'b00 && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("drain_timeout", 32'(busy_w), 0);

        // Reset in the middle of stage 2 of the small configuration.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_rd_en0", 32'(rd_en_w[0]), 1);
        check("pre_rst_stage0", 32'(stage_w[0]), 2);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        $display("txn mid_reset applied");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn("post_rst", 0, 0, 1'b0, 0, l0, l1, r0, r1);
        check("post_rst_lat0", l0, 16);
        check("post_rst_lat1", l1, 1282);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_read_sequencer.md
# butterfly_read_sequencer

Per-stage read sequencer for the radix-2 FFT datapath. It walks every stage of an N-point transform and issues paired row reads to the two 128-bit coefficient SRAM ports (4 × 32-bit lanes per row). Alongside each pair of reads it produces the stride that the butterfly input crossbar needs, delayed to line up with the returning read data. It sits directly upstream of the input crossbar and drives its stride select.

## Interface
Parameters:
- N_LOG2, default 10: log2 of transform size; legal range 4..10, so the maximum stride N/2 fits in 10 bits.
- STAGE_GAP, default 2: idle cycles inserted between stages so that butterfly write-back can drain; legal range 0..15.

Ports (ROW_W = N_LOG2-2):
- i_CLK  in  1  clock; all logic on rising edge.
- i_RST_N  in  1  reset, asynchronous, active-low.
- i_START  in  1  start a full transform; sampled only in IDLE.
- i_STALL  in  1  backpressure from the butterfly pipeline; freezes issue.
- o_BUSY  out  1  high from the cycle after START is accepted until DONE is asserted.
- o_RD_EN  out  1  read strobe for both SRAM ports.
- o_RD_ADDR1  out  ROW_W  top row address, to the port that produces read output 1.
- o_RD_ADDR2  out  ROW_W  bottom row address, to the port that produces read output 2.
- o_STAGE  out  4  index of the stage being issued (0 = first).
- o_DATA_VALID  out  1  o_RD_EN delayed by one cycle (SRAM read latency is 1).
- o_DATA_STRIDE  out  10  stride of the read whose data is arriving; feeds the crossbar stride input.
- o_DONE  out  1  one-cycle pulse at the end of the transform.

## Operation
- Stage s (0..N_LOG2-1) uses stride S = N >> (s+1), so strides run N/2 down to 1.
- Each stage issues N/8 row pairs, indexed by pair counter p = 0..N/8-1.
- Row distance k = max(S/4, 1).
- Row A = p with a 0 bit inserted at bit position log2(k). Row B = A + k.
  - For S ≤ 2 this gives consecutive rows (2p, 2p+1).
- State machine states: IDLE, READ, GAP, FIN.
  - IDLE → READ when i_START=1; s and p are cleared.
  - READ: each cycle with i_STALL=0 sets o_RD_EN=1, drives A/B, and increments p. The last pair of a stage moves to GAP, or to FIN if this is the last stage. When STAGE_GAP=0 the machine goes straight to READ of stage s+1.
  - GAP: a counter runs STAGE_GAP cycles, then s increments and the machine returns to READ. i_STALL is ignored in GAP.
  - FIN: waits one cycle for the final o_DATA_VALID, pulses o_DONE, then returns to IDLE.
- i_STALL=1 in READ: o_RD_EN=0; p, s, addresses and o_STAGE hold.
- i_START while busy is ignored.
- The stage stride register tracks s. o_DATA_STRIDE is the registered stride of the previous cycle's read and updates only when o_RD_EN was 1.
- Reset (at any time, including mid-transform): the machine returns to IDLE immediately.
  - All outputs go to 0: o_BUSY, o_RD_EN, o_RD_ADDR1/2, o_STAGE, o_DATA_VALID, o_DATA_STRIDE, o_DONE.
  - All counters clear.

## Timing
- START sampled high in IDLE at edge t:
  - o_BUSY=1 from t+1.
  - The first o_RD_EN is high in the cycle following edge t+1; the state register updates at t+1.
- Issue throughput: 1 row pair per non-stalled READ cycle.
- Stage length: N/8 read cycles plus stall cycles, plus STAGE_GAP cycles (none after the last stage).
- o_DATA_VALID and o_DATA_STRIDE lag o_RD_EN by exactly 1 cycle.
- o_DONE is high exactly one cycle: the cycle after the last o_DATA_VALID. o_BUSY falls in the same cycle o_DONE rises.
- Total with no stalls: N_LOG2·N/8 + (N_LOG2-1)·STAGE_GAP + 2 cycles from acceptance to o_DONE.

## Test plan
- N_LOG2=4, STAGE_GAP=2, no stall: one START yields 8 reads.
  - Row pairs: (0,2), (1,3) at stride 8; (0,1), (2,3) at stride 4; then stride 2; then stride 1.
  - Each o_DATA_STRIDE value appears one cycle after its read.
  - o_DONE pulses once, 16 cycles after acceptance.
- N_LOG2=10, STAGE_GAP=0:
  - Stage 0 (stride 512, k=128): pairs (0,128) … (127,255).
  - Stage 7 (stride 4, k=1): pairs (0,1), (2,3), …
  - 1280 reads total; no idle cycle between stages.
- Stall: assert i_STALL for 3 cycles mid-stage-1.
  - o_RD_EN low for those 3 cycles; addresses held.
  - Resumes at the next pair with no pair skipped or repeated; o_DONE is 3 cycles later than the unstalled run.
- START pulsed while o_BUSY=1: ignored; the sequence and o_DONE timing are unchanged.
- Reset asserted mid-stage-2: all outputs are 0 asynchronously. After release, a new START restarts from stage 0, pair 0, stride N/2.
- Back-to-back transforms: START asserted in the cycle after o_DONE is accepted. The second run is identical to the first.
